shift_reg_univ: RTL and testbench
=================================

# shift_reg_univ

Parametrised universal shift register: the next generation of the team's single-bit edge flip-flops, widened to a WIDTH-bit register with hold, left shift, right shift, rotate and parallel-load modes. A shift counter with an empty flag lets it serve directly as a serializer or deserializer stage. It sits between datapath logic and serial links in the sequential-logic library and is clocked on the rising edge only.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64.
- RST_VAL, 0, value loaded into o_q on reset and on synchronous clear.
- CW, $clog2(WIDTH+1), localparam; width of o_cnt.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rstn  input  1  reset, asynchronous and active-low.
- i_en  input  1  operation enable; low means hold.
- i_clr  input  1  synchronous clear; takes priority over i_en.
- i_mode  input  2  operation: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
- i_rot  input  1  1 means the shifts rotate (the exiting bit re-enters) instead of taking i_sin.
- i_sin  input  1  serial input bit.
- i_d  input  WIDTH  parallel load data.
- o_q  output  WIDTH  register contents.
- o_sout  output  1  registered; the bit that left the register on the most recent shift.
- o_cnt  output  CW  shifts since the last load, saturating at WIDTH.
- o_empty  output  1  combinational, equal to (o_cnt == WIDTH).

## Operation
- Async reset (i_rstn low): o_q=RST_VAL, o_sout=0, o_cnt=WIDTH, so o_empty=1. Reset applies immediately, including mid-shift.
- Priority each edge: i_clr, then i_en low (hold everything), then i_mode.
- i_clr=1: o_q=RST_VAL, o_sout=0, o_cnt=WIDTH, regardless of i_en or i_mode.
- Mode 00: no state change, even with i_en=1.
- Mode 01 (left): o_q <= {o_q[WIDTH-2:0], b}. b is o_q[WIDTH-1] when i_rot=1, otherwise i_sin. o_sout <= o_q[WIDTH-1].
- Mode 10 (right): o_q <= {b, o_q[WIDTH-1:1]}. b is o_q[0] when i_rot=1, otherwise i_sin. o_sout <= o_q[0].
- Mode 11 (load): o_q <= i_d, o_sout <= 0, o_cnt <= 0.
- Every enabled shift, rotate included, increments o_cnt, saturating at WIDTH. Shifting while empty continues to move data; o_cnt stays at WIDTH.
- A load and a shift cannot occur in the same cycle (single mode field); a load always restarts the count.
- i_sin is ignored while i_rot=1. i_d is ignored outside mode 11.

## Timing
- One-cycle latency: o_q, o_sout and o_cnt reflect the inputs sampled on the previous rising edge.
- o_empty is combinational from o_cnt only, with no input-to-output combinational path.
- After a load, exactly WIDTH enabled shifts take o_empty from 0 to 1. o_empty rises in the cycle after the WIDTH-th shift edge.
- Inputs must meet setup and hold to the rising edge. i_rstn deassertion is synchronised externally.

## Structure
- The mode encodings (HOLD, SHL, SHR, LOAD) go in the shared sequential-logic defines header for reuse by the bench and by later serializer blocks.
- One sub-module is natural: sat_counter (parametrised saturating up-counter with sync load-to-zero and load-to-max), instantiated for o_cnt.
- Everything else is a single always block for the data and o_sout registers.

## Test plan
All scenarios use WIDTH=8 and RST_VAL=8'hA5.
- Reset: hold i_rstn low mid-cycle -> o_q=8'hA5, o_sout=0, o_cnt=8, o_empty=1, asynchronously before the next edge.
- Load then 8 left shifts: i_d=8'hC3, i_sin=0, i_rot=0 -> o_sout sequence 1,1,0,0,0,0,1,1. Final o_q=8'h00, o_cnt=8, o_empty=1 after the 8th edge.
- Right rotate: load 8'h81, 3 right shifts with i_rot=1 -> o_q=8'h30, o_sout=0, o_cnt=3, o_empty=0.
- Enable and hold: load 8'h5A, then i_en=0 with mode 01 for 4 cycles, then i_en=1 with mode 00 for 4 cycles -> o_q stays 8'h5A, o_cnt stays 0.
- Clear priority: i_clr=1 together with i_en=1, mode 11, i_d=8'hFF -> o_q=8'hA5, o_cnt=8, o_sout=0.
- Saturation and reload: 10 shifts after a load -> o_cnt holds at 8. A subsequent load of 8'h01 -> o_cnt=0, o_empty=0. Random-stimulus run checked against a reference model.

Source files
------------

// File: rtl/shift_reg_univ_pkg.sv
// Shared definitions for the universal shift register: operation mode encodings.
package shift_reg_univ_pkg;

  typedef enum logic [1:0] {
    ModeHold = 2'b00,
    ModeShl  = 2'b01,
    ModeShr  = 2'b10,
    ModeLoad = 2'b11
  } mode_e;

  localparam int unsigned MinWidth = 2;
  localparam int unsigned MaxWidth = 64;

endpackage

// File: rtl/shift_reg_univ_sat_counter.sv
// Saturating up-counter with synchronous load-to-zero and load-to-max; resets to max.
module shift_reg_univ_sat_counter #(
  parameter int unsigned MAX   = 8,
  parameter int unsigned CNT_W = $clog2(MAX + 1)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_load_max,
  input  logic             i_load_zero,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_at_max
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load_max) begin
      cnt_d = CntMax;
    end else if (i_load_zero) begin
      cnt_d = '0;
    end else if (i_inc && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q <= CntMax;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt    = cnt_q;
  assign o_at_max = (cnt_q == CntMax);

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, shift/rotate left and right, parallel load, with a
// saturating shift counter whose full state doubles as the serializer empty flag.
module shift_reg_univ
  import shift_reg_univ_pkg::*;
#(
  parameter int unsigned       WIDTH   = 8,
  parameter logic [WIDTH-1:0]  RST_VAL = '0,
  localparam int unsigned      CW      = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [1:0]       i_mode,
  input  logic             i_rot,
  input  logic             i_sin,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_sout,
  output logic [CW-1:0]    o_cnt,
  output logic             o_empty
);

  mode_e            mode;
  logic             shift_op, load_op;
  logic             left_in, right_in;
  logic [WIDTH-1:0] q_q;
  logic             sout_q;

  assign mode     = mode_e'(i_mode);
  assign shift_op = !i_clr && i_en && ((mode == ModeShl) || (mode == ModeShr));
  assign load_op  = !i_clr && i_en && (mode == ModeLoad);
  assign left_in  = i_rot ? q_q[WIDTH-1] : i_sin;
  assign right_in = i_rot ? q_q[0] : i_sin;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      q_q    <= RST_VAL;
      sout_q <= 1'b0;
    end else if (i_clr) begin
      q_q    <= RST_VAL;
      sout_q <= 1'b0;
    end else if (i_en) begin
      unique case (mode)
        ModeShl: begin
          q_q    <= {q_q[WIDTH-2:0], left_in};
          sout_q <= q_q[WIDTH-1];
        end
        ModeShr: begin
          q_q    <= {right_in, q_q[WIDTH-1:1]};
          sout_q <= q_q[0];
        end
        ModeLoad: begin
          q_q    <= i_d;
          sout_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Clear forces the count to full so a cleared register reads as empty.
  shift_reg_univ_sat_counter #(
    .MAX   (WIDTH),
    .CNT_W (CW)
  ) u_cnt (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_load_max  (i_clr),
    .i_load_zero (load_op),
    .i_inc       (shift_op),
    .o_cnt       (o_cnt),
    .o_at_max    (o_empty)
  );

  assign o_q    = q_q;
  assign o_sout = sout_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed and model-checked random bench for shift_reg_univ with WIDTH=8, RST_VAL=8'hA5.
module tb_shift_reg_univ;

  localparam int unsigned W = 8;
  localparam logic [7:0]  RV = 8'hA5;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en, clr, rot, sin;
  logic [1:0] mode;
  logic [7:0] d;
  logic [7:0] q;
  logic       sout;
  logic [3:0] cnt;
  logic       empty;

  int tests = 0;
  int fails = 0;

  shift_reg_univ #(
    .WIDTH   (W),
    .RST_VAL (RV)
  ) dut (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_en    (en),
    .i_clr   (clr),
    .i_mode  (mode),
    .i_rot   (rot),
    .i_sin   (sin),
    .i_d     (d),
    .o_q     (q),
    .o_sout  (sout),
    .o_cnt   (cnt),
    .o_empty (empty)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic c, input logic [1:0] m, input logic r,
                       input logic s, input logic [7:0] dd);
    en = e; clr = c; mode = m; rot = r; sin = s; d = dd;
  endtask

  task automatic load(input logic [7:0] v);
    drive(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, v);
    step();
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 8'h3C);
    step();
    // Assert reset mid-cycle and check before the next rising edge.
    #2 rstn = 1'b0;
    #1;
    tests++;
    if (q !== RV || sout !== 1'b0 || cnt !== 4'd8 || empty !== 1'b1) begin
      fails++;
      $display("FAIL reset: q=%h sout=%b cnt=%0d empty=%b, want q=%h sout=0 cnt=8 empty=1",
               q, sout, cnt, empty, RV);
    end
    step();
    rstn = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
    step();
  endtask

  task automatic test_shift_left();
    logic [7:0] exp_sout;
    exp_sout = 8'b1100_0011;
    load(8'hC3);
    tests++;
    if (cnt !== 4'd0 || empty !== 1'b0) begin
      fails++;
      $display("FAIL load_cnt: cnt=%0d empty=%b, want cnt=0 empty=0", cnt, empty);
    end
    drive(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      step();
      tests++;
      if (sout !== exp_sout[7-i]) begin
        fails++;
        $display("FAIL shl_sout[%0d]: got %b, want %b", i, sout, exp_sout[7-i]);
      end
      if (i == 6) begin
        tests++;
        if (cnt !== 4'd7 || empty !== 1'b0) begin
          fails++;
          $display("FAIL shl_cnt7: cnt=%0d empty=%b, want cnt=7 empty=0", cnt, empty);
        end
      end
    end
    tests++;
    if (q !== 8'h00 || cnt !== 4'd8 || empty !== 1'b1) begin
      fails++;
      $display("FAIL shl_final: q=%h cnt=%0d empty=%b, want q=00 cnt=8 empty=1", q, cnt, empty);
    end
  endtask

  task automatic test_rotate_right();
    load(8'h81);
    drive(1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 8'h00);
    step();
    tests++;
    if (q !== 8'hC0 || sout !== 1'b1) begin
      fails++;
      $display("FAIL rotr_first: q=%h sout=%b, want q=c0 sout=1", q, sout);
    end
    step();
    step();
    tests++;
    if (q !== 8'h30 || sout !== 1'b0 || cnt !== 4'd3 || empty !== 1'b0) begin
      fails++;
      $display("FAIL rotr: q=%h sout=%b cnt=%0d empty=%b, want q=30 sout=0 cnt=3 empty=0",
               q, sout, cnt, empty);
    end
  endtask

  task automatic test_hold();
    load(8'h5A);
    drive(1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 8'hFF);
    repeat (4) step();
    tests++;
    if (q !== 8'h5A || cnt !== 4'd0) begin
      fails++;
      $display("FAIL hold_en0: q=%h cnt=%0d, want q=5a cnt=0", q, cnt);
    end
    drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 8'hFF);
    repeat (4) step();
    tests++;
    if (q !== 8'h5A || cnt !== 4'd0 || sout !== 1'b0) begin
      fails++;
      $display("FAIL hold_mode0: q=%h cnt=%0d sout=%b, want q=5a cnt=0 sout=0", q, cnt, sout);
    end
  endtask

  task automatic test_clear();
    load(8'h0F);
    drive(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00);
    step();
    drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 8'hFF);
    step();
    tests++;
    if (q !== RV || cnt !== 4'd8 || sout !== 1'b0 || empty !== 1'b1) begin
      fails++;
      $display("FAIL clear: q=%h cnt=%0d sout=%b empty=%b, want q=a5 cnt=8 sout=0 empty=1",
               q, cnt, sout, empty);
    end
  endtask

  task automatic test_saturation();
    load(8'h96);
    drive(1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 8'h00);
    repeat (10) step();
    tests++;
    // Rotating 10 times left equals rotating 2 times left.
    if (cnt !== 4'd8 || empty !== 1'b1 || q !== 8'h5A) begin
      fails++;
      $display("FAIL saturate: cnt=%0d empty=%b q=%h, want cnt=8 empty=1 q=5a", cnt, empty, q);
    end
    load(8'h01);
    tests++;
    if (cnt !== 4'd0 || empty !== 1'b0 || q !== 8'h01) begin
      fails++;
      $display("FAIL reload: cnt=%0d empty=%b q=%h, want cnt=0 empty=0 q=01", cnt, empty, q);
    end
  endtask

  task automatic test_random();
    logic [7:0] m_q;
    logic       m_sout, b;
    int         m_cnt;
    m_q = 8'h01; m_sout = 1'b0; m_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
            2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 8'($urandom));
      if (clr) begin
        m_q = RV; m_sout = 1'b0; m_cnt = 8;
      end else if (en) begin
        case (mode)
          2'b01: begin
            b = rot ? m_q[7] : sin;
            m_sout = m_q[7];
            m_q = {m_q[6:0], b};
            if (m_cnt < 8) m_cnt++;
          end
          2'b10: begin
            b = rot ? m_q[0] : sin;
            m_sout = m_q[0];
            m_q = {b, m_q[7:1]};
            if (m_cnt < 8) m_cnt++;
          end
          2'b11: begin
            m_q = d; m_sout = 1'b0; m_cnt = 0;
          end
          default: ;
        endcase
      end
      step();
      tests++;
      if (q !== m_q || sout !== m_sout || cnt !== 4'(m_cnt) || empty !== (m_cnt == 8)) begin
        fails++;
        $display("FAIL random[%0d]: q=%h sout=%b cnt=%0d empty=%b, want q=%h sout=%b cnt=%0d",
                 i, q, sout, cnt, empty, m_q, m_sout, m_cnt);
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
    step();
    rstn = 1'b1;
    step();
    test_reset();
    test_shift_left();
    test_rotate_right();
    test_hold();
    test_clear();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
